change_dispenser: RTL

- Sequences the three coin hoppers (10 yuan, 1 yuan, 0.5 yuan) to pay out change or a refund when the vending FSM enters its charge state.
- Takes a Q1 amount (half-yuan units; 1 yuan = 2) and dispenses greedily, largest coin first, one coin at a time.
- Each coin is confirmed by the hopper exit sensor; a per-coin timeout puts the block into a fault state.
- Sits between the vending FSM (coin_sum/charge_ind) and the hopper motor drivers.

---
 rtl/change_dispenser_pkg.sv | 55 +++++
 rtl/change_dispenser_if.sv | 27 ++
 rtl/change_dispenser_timer.sv | 24 ++
 rtl/change_dispenser.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin values, Q1 width,
// FSM states and the coin-select encoding with its helpers.
package vend_pkg;

  localparam int SUM_W = 6;

  localparam logic [SUM_W-1:0] VAL_10 = 6'd20;
  localparam logic [SUM_W-1:0] VAL_1  = 6'd2;
  localparam logic [SUM_W-1:0] VAL_05 = 6'd1;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    DRIVE,
    WAIT,
    GAP,
    DONE,
    FAULT
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_10,
    COIN_1,
    COIN_05
  } coin_e;

  // Greedy choice: largest coin that still fits in the remaining amount.
  function automatic coin_e pick_coin(input logic [SUM_W-1:0] rem);
    if (rem >= VAL_10)     return COIN_10;
    else if (rem >= VAL_1) return COIN_1;
    else if (rem == VAL_05) return COIN_05;
    else                   return COIN_NONE;
  endfunction

  function automatic logic [SUM_W-1:0] coin_value(input coin_e c);
    case (c)
      COIN_10: return VAL_10;
      COIN_1:  return VAL_1;
      COIN_05: return VAL_05;
      default: return '0;
    endcase
  endfunction

  // Drive vector ordering is {hop10, hop1, hop05}.
  function automatic logic [2:0] coin_drv(input coin_e c);
    case (c)
      COIN_10: return 3'b100;
      COIN_1:  return 3'b010;
      COIN_05: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/status and hopper-drive bundle between the vending FSM side
// (master) and the change dispenser (slave).
interface change_dispenser_if;

  logic                       start;
  logic [vend_pkg::SUM_W-1:0] amount;
  logic                       coin_sense;
  logic                       clr_fault;
  logic                       busy;
  logic                       done;
  logic                       fault;
  logic                       hop10_drv;
  logic                       hop1_drv;
  logic                       hop05_drv;
  logic [vend_pkg::SUM_W-1:0] remaining;

  modport master (
    output start, amount, coin_sense, clr_fault,
    input  busy, done, fault, hop10_drv, hop1_drv, hop05_drv, remaining
  );

  modport slave (
    input  start, amount, coin_sense, clr_fault,
    output busy, done, fault, hop10_drv, hop1_drv, hop05_drv, remaining
  );

endinterface

// File: rtl/change_dispenser_timer.sv
// Loadable 8-bit down-counter that stops at zero; zero flag is taken
// straight from the count register.
module dispense_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       zero
);

  logic [7:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (load)            cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 8'd1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin payout sequencer: one coin at a time, largest first, each
// confirmed by the hopper exit sensor with a per-coin timeout to FAULT.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned PULSE_CYC   = 4,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic              clk,
  input logic              rst_n,
  change_dispenser_if.slave dif
);

  // Counters are loaded with N-1 so the zero flag is seen in the Nth cycle.
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);
  localparam logic [7:0] TMO_LD   = 8'(TIMEOUT_CYC - 1);

  state_e           state;
  coin_e            coin;
  logic [2:0]       drv;
  logic [SUM_W-1:0] remaining;
  logic             busy, done, fault;

  logic       pulse_load, pulse_en, pulse_zero;
  logic [7:0] pulse_val;
  logic       tmo_load, tmo_en, tmo_zero;
  coin_e      next_coin;

  assign next_coin = pick_coin(remaining);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    pulse_load = 1'b0;
    pulse_val  = PULSE_LD;
    pulse_en   = 1'b0;
    tmo_load   = 1'b0;
    tmo_en     = 1'b0;
    case (state)
      SELECT: if (remaining != '0) begin
        pulse_load = 1'b1;
        tmo_load   = 1'b1;
      end
      DRIVE, WAIT: begin
        tmo_en = 1'b1;
        if (dif.coin_sense) begin
          pulse_load = 1'b1;
          pulse_val  = GAP_LD;
        end else begin
          pulse_en = (state == DRIVE);
        end
      end
      GAP:     pulse_en = 1'b1;
      default: ;
    endcase
  end

  dispense_timer u_pulse_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pulse_load),
    .load_val (pulse_val),
    .en       (pulse_en),
    .zero     (pulse_zero)
  );

  dispense_timer u_tmo_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmo_load),
    .load_val (TMO_LD),
    .en       (tmo_en),
    .zero     (tmo_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      coin      <= COIN_NONE;
      drv       <= 3'b000;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (dif.start) begin
          remaining <= dif.amount;
          busy      <= 1'b1;
          state     <= SELECT;
        end
        SELECT: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            coin  <= next_coin;
            drv   <= coin_drv(next_coin);
            state <= DRIVE;
          end
        end
        DRIVE, WAIT: begin
          // A sense on the timeout cycle itself still counts as a paid coin.
          if (dif.coin_sense) begin
            remaining <= remaining - coin_value(coin);
            drv       <= 3'b000;
            state     <= GAP;
          end else if (tmo_zero) begin
            drv   <= 3'b000;
            fault <= 1'b1;
            state <= FAULT;
          end else if (state == DRIVE && pulse_zero) begin
            drv   <= 3'b000;
            state <= WAIT;
          end
        end
        GAP: if (pulse_zero) state <= SELECT;
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        FAULT: if (dif.clr_fault) begin
          fault     <= 1'b0;
          busy      <= 1'b0;
          remaining <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dif.busy      = busy;
  assign dif.done      = done;
  assign dif.fault     = fault;
  assign dif.hop10_drv = drv[2];
  assign dif.hop1_drv  = drv[1];
  assign dif.hop05_drv = drv[0];
  assign dif.remaining = remaining;

endmodule
